mdio_phy_responder: RTL and testbench
=====================================

Name: mdio_phy_responder

Overview:
- Clause-22 MDIO responder (PHY side) and the counterpart of the management-side MDIO initiator.
- Oversamples MDC/MDIO on the 50 MHz system clock and decodes write and read frames addressed to PHY_ADDR.
- Serves a 32 x 16 register file, driving read data back onto MDIO.
- Used as the PHY model in system simulation and as an FPGA-side management slave.

Parameters:
- PHY_ADDR, 5'd1, PHY address this responder answers to.
- PREAMBLE_MIN, 32, consecutive MDIO ones required before a start-of-frame is accepted.
- REG0_RST, 16'h1140, reset value of register 0 (control).
- REG2_RST, 16'h0141, reset value of register 2 (PHY ID1); register 3 resets to 16'h0DD1.

Ports:
- clock_50m  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- phy_mdc  in  1  MDC from the initiator, asynchronous to clock_50m, at most 1 MHz.
- mdio_i  in  1  MDIO pad input.
- mdio_o  out  1  MDIO drive value.
- mdio_oe  out  1  MDIO output enable (1 = drive); the pad tristate sits outside this block.
- link_up  in  1  reflected live in register 1 bit 2.
- wr_valid  out  1  one-cycle pulse when a write to this PHY commits.
- wr_addr  out  5  register address of the last committed write.
- wr_data  out  16  data of the last committed write.
- rd_valid  out  1  one-cycle pulse when a read to this PHY is accepted (at turnaround start).
- frame_err  out  1  one-cycle pulse on a malformed or aborted frame.
- busy  out  1  high from the start-of-frame 0 until the frame ends or aborts.

Behaviour:
- Synchronisers: phy_mdc and mdio_i each pass through 2 flops, plus a third flop on MDC for edge detect.
  - The rise pulse is one clock_50m cycle; the fall pulse likewise.
  - All bit sampling occurs on the rise pulse using synchronised MDIO.
- Reset state: all outputs 0; state IDLE; preamble count 0.
  - Register file: reg0 = REG0_RST, reg2 = REG2_RST, reg3 = 16'h0DD1, all others 0.
- States and transitions:
  - IDLE: count consecutive 1s on rises, saturating at PREAMBLE_MIN. A 0 with count < PREAMBLE_MIN clears the count and stays in IDLE. A 0 with count = PREAMBLE_MIN goes to ST; busy goes to 1.
  - ST: expect 1. A 0 gives frame_err and a return to IDLE.
  - OP: 2 bits. 01 = write, 10 = read; 00/11 give frame_err and IDLE.
  - PHYAD: 5 bits, MSB first.
  - REGAD: 5 bits, MSB first. On the 5th bit, a read with PHYAD == PHY_ADDR latches the 16-bit read word and pulses rd_valid.
  - TA: 2 bits.
    - Write: first TA bit must be 1, else frame_err.
    - Read: the first fall after TA entry keeps mdio_oe = 0; the second fall sets mdio_oe = 1, mdio_o = 0.
  - DATA: 16 bits.
    - Write: shift on rises.
    - Read: on each of the next 16 falls, mdio_o = D15..D0. On the fall after D0, mdio_oe = 0 and the state returns to IDLE.
- Write commit: on the rise sampling D0, if PHYAD == PHY_ADDR, in the next cycle update the register, set wr_addr/wr_data, and pulse wr_valid.
- Register rules:
  - reg1 is read-only. Its value is 16'h7949 with bit 2 replaced by link_up sampled at the read latch.
  - reg2 and reg3 are read-only; writes to them are ignored but still pulse wr_valid.
  - reg0 bit 15 (soft reset) self-clears: one cycle after commit, reg0 = REG0_RST.
  - reg0 bit 9 (restart AN) self-clears one cycle after commit.
- Non-matching PHYAD: the frame is still tracked to its end for resync. The block never drives MDIO, and there is no wr_valid or rd_valid.
- End of frame: busy = 0 and preamble count = 0. The next frame needs a full preamble.
- Mid-frame MDC idle: MDC with no edge for 2^16 clocks aborts the frame, giving frame_err, mdio_oe = 0, and IDLE.
- Reset mid-operation: mdio_oe drops to 0 in the cycle after reset is sampled. The register file returns to reset values and there is no wr_valid.
- Simultaneous rise and fall pulses cannot occur. Rise and fall work is processed in one case statement.

Test Plan:
- Write 24'h001900 framed (32-one preamble, ST 01, OP 01, PHYAD 1, REGAD 0, TA 10, data 16'h1900) → wr_valid once with wr_addr = 0, wr_data = 16'h1900; a subsequent read of reg0 returns 16'h1900.
- Write reg0 = 16'h9140 → after commit reg0 reads 16'h1140 (soft reset self-clears); write 16'h1340 → reads 16'h1140.
- Read reg2 → mdio_oe high from the 2nd TA fall; TA bit 0, then 0x0141 MSB first; mdio_oe low after D0; rd_valid once.
- Read reg1 with link_up = 1 → 16'h794D; with link_up = 0 → 16'h7949.
- Frame with PHYAD 5 → no wr_valid or rd_valid and mdio_oe stays 0 throughout; a following valid frame with a full preamble is accepted.
- Preamble of 31 ones then ST → ignored, no busy; OP 11 after a valid preamble → frame_err; MDC stopped mid-data or reset during read data → mdio_oe 0, IDLE.

Source files
------------

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO responder (PHY side).
// MDC/MDIO are oversampled on clock_50m; frames addressed to PHY_ADDR read or
// write a 32 x 16 register file, and read data is driven back on MDIO.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int          PREAMBLE_MIN = 32,
    parameter logic [15:0] REG0_RST     = 16'h1140,
    parameter logic [15:0] REG2_RST     = 16'h0141
) (
    input  logic        clock_50m,
    input  logic        reset,
    input  logic        phy_mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        link_up,
    output logic        wr_valid,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        rd_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [15:0] REG3_RST = 16'h0DD1;
    localparam logic [15:0] REG1_VAL = 16'h7949;
    localparam int          PCW      = $clog2(PREAMBLE_MIN + 1);
    localparam logic [PCW-1:0] PRE_MAX = PCW'(PREAMBLE_MIN);

    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        mdc_sync_q, mdc_sync_d;
    logic [1:0]        mdio_sync_q, mdio_sync_d;
    logic [PCW-1:0]    pre_cnt_q, pre_cnt_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic              is_read_q, is_read_d;
    logic              match_q, match_d;
    logic [4:0]        phyad_q, phyad_d;
    logic [4:0]        regad_q, regad_d;
    logic [15:0]       shift_q, shift_d;
    logic [15:0]       idle_cnt_q, idle_cnt_d;
    logic [31:0][15:0] regs_q, regs_d;
    logic              mdio_o_q, mdio_o_d;
    logic              mdio_oe_q, mdio_oe_d;
    logic              wr_valid_q, wr_valid_d;
    logic [4:0]        wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    logic              rise, fall, bit_in;
    logic              err, done, tmo;
    logic [4:0]        rd_addr;
    logic [15:0]       rd_word, wr_word;

    // Frame decoder, register file and MDIO drive: all next-state logic.
    always_comb begin
        state_d     = state_q;
        mdc_sync_d  = {mdc_sync_q[1:0], phy_mdc};
        mdio_sync_d = {mdio_sync_q[0], mdio_i};
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        is_read_d   = is_read_q;
        match_d     = match_q;
        phyad_d     = phyad_q;
        regad_d     = regad_q;
        shift_d     = shift_q;
        idle_cnt_d  = idle_cnt_q;
        regs_d      = regs_q;
        mdio_o_d    = mdio_o_q;
        mdio_oe_d   = mdio_oe_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = busy_q;
        err         = 1'b0;
        done        = 1'b0;
        tmo         = 1'b0;

        rise    = mdc_sync_q[1] & ~mdc_sync_q[2];
        fall    = ~mdc_sync_q[1] & mdc_sync_q[2];
        bit_in  = mdio_sync_q[1];
        rd_addr = {regad_q[3:0], bit_in};
        rd_word = (rd_addr == 5'd1) ? {REG1_VAL[15:3], link_up, REG1_VAL[1:0]}
                                    : regs_q[rd_addr];
        wr_word = {shift_q[14:0], bit_in};

        // Soft reset restores the whole control word; restart-AN just drops.
        if (regs_q[0][15])
            regs_d[0] = REG0_RST;
        else if (regs_q[0][9])
            regs_d[0][9] = 1'b0;

        case (state_q)
            S_IDLE: if (rise) begin
                if (bit_in) begin
                    if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 1'b1;
                end else if (pre_cnt_q == PRE_MAX) begin
                    state_d   = S_ST;
                    busy_d    = 1'b1;
                    pre_cnt_d = '0;
                end else begin
                    pre_cnt_d = '0;
                end
            end
            S_ST: if (rise) begin
                if (bit_in) begin
                    state_d   = S_OP;
                    bit_cnt_d = '0;
                end else begin
                    err = 1'b1;
                end
            end
            // First opcode bit is 1 for read; the second must be its complement.
            S_OP: if (rise) begin
                if (bit_cnt_q == 5'd0) begin
                    is_read_d = bit_in;
                    bit_cnt_d = 5'd1;
                end else if (bit_in == is_read_q) begin
                    err = 1'b1;
                end else begin
                    state_d   = S_PHYAD;
                    bit_cnt_d = '0;
                end
            end
            S_PHYAD: if (rise) begin
                phyad_d = {phyad_q[3:0], bit_in};
                if (bit_cnt_q == 5'd4) begin
                    state_d   = S_REGAD;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_REGAD: if (rise) begin
                regad_d = rd_addr;
                if (bit_cnt_q == 5'd4) begin
                    match_d   = (phyad_q == PHY_ADDR);
                    state_d   = S_TA;
                    bit_cnt_d = '0;
                    if (is_read_q && phyad_q == PHY_ADDR) begin
                        shift_d    = rd_word;
                        rd_valid_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            // Read turnaround is paced by falls: release, then drive the 0.
            S_TA: if (is_read_q) begin
                if (fall) begin
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                    end else begin
                        mdio_oe_d = match_q;
                        mdio_o_d  = 1'b0;
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end else if (rise) begin
                if (bit_cnt_q == 5'd0) begin
                    if (!bit_in) err = 1'b1;
                    else         bit_cnt_d = 5'd1;
                end else begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: if (is_read_q) begin
                if (fall) begin
                    if (bit_cnt_q == 5'd16) begin
                        done = 1'b1;
                    end else begin
                        mdio_o_d  = match_q & shift_q[15];
                        shift_d   = {shift_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end else if (rise) begin
                shift_d = wr_word;
                if (bit_cnt_q == 5'd15) begin
                    done = 1'b1;
                    if (match_q) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = regad_q;
                        wr_data_d  = wr_word;
                        if (regad_q > 5'd3 || regad_q == 5'd0)
                            regs_d[regad_q] = wr_word;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: err = 1'b1;
        endcase

        // A stalled MDC mid-frame must not leave the pad driven forever.
        if (state_q != S_IDLE) begin
            if (rise || fall)             idle_cnt_d = '0;
            else if (idle_cnt_q == '1)    tmo = 1'b1;
            else                          idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_d = '0;
        end

        if (err || done || tmo) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            pre_cnt_d   = '0;
            bit_cnt_d   = '0;
            idle_cnt_d  = '0;
            mdio_oe_d   = 1'b0;
            mdio_o_d    = 1'b0;
            frame_err_d = err | tmo;
        end
    end

    // State register with synchronous reset to the power-on register image.
    always_ff @(posedge clock_50m) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mdc_sync_q  <= '0;
            mdio_sync_q <= '0;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            is_read_q   <= 1'b0;
            match_q     <= 1'b0;
            phyad_q     <= '0;
            regad_q     <= '0;
            shift_q     <= '0;
            idle_cnt_q  <= '0;
            regs_q      <= '0;
            regs_q[0]   <= REG0_RST;
            regs_q[2]   <= REG2_RST;
            regs_q[3]   <= REG3_RST;
            mdio_o_q    <= 1'b0;
            mdio_oe_q   <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mdc_sync_q  <= mdc_sync_d;
            mdio_sync_q <= mdio_sync_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            is_read_q   <= is_read_d;
            match_q     <= match_d;
            phyad_q     <= phyad_d;
            regad_q     <= regad_d;
            shift_q     <= shift_d;
            idle_cnt_q  <= idle_cnt_d;
            regs_q      <= regs_d;
            mdio_o_q    <= mdio_o_d;
            mdio_oe_q   <= mdio_oe_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_valid_q  <= rd_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_valid  = rd_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: drives MDC/MDIO frames like a
// management initiator and checks pulses, register contents and MDIO drive.
module tb_mdio_phy_responder;

    localparam int HP = 4;  // MDC half period in clock_50m cycles

    logic        clock_50m = 1'b0;
    logic        reset     = 1'b1;
    logic        phy_mdc   = 1'b0;
    logic        mdio_i    = 1'b1;
    logic        link_up   = 1'b0;
    logic        mdio_o, mdio_oe, wr_valid, rd_valid, frame_err, busy;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int vectors = 0, miscompares = 0;
    int wr_pulses = 0, rd_pulses = 0, err_pulses = 0, busy_cyc = 0, oe_cyc = 0;

    mdio_phy_responder dut (
        .clock_50m(clock_50m), .reset(reset), .phy_mdc(phy_mdc),
        .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
        .link_up(link_up), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_valid(rd_valid), .frame_err(frame_err),
        .busy(busy)
    );

    always #10 clock_50m = ~clock_50m;

    // Pulse/level counters sampled away from the active edge.
    always @(negedge clock_50m) begin
        if (wr_valid)  wr_pulses  <= wr_pulses + 1;
        if (rd_valid)  rd_pulses  <= rd_pulses + 1;
        if (frame_err) err_pulses <= err_pulses + 1;
        if (busy)      busy_cyc   <= busy_cyc + 1;
        if (mdio_oe)   oe_cyc     <= oe_cyc + 1;
    end

    task automatic mdc_bit(input logic b);
        mdio_i = b;
        repeat (HP) @(posedge clock_50m);
        #1 phy_mdc = 1'b1;
        repeat (HP) @(posedge clock_50m);
        #1 phy_mdc = 1'b0;
    endtask

    // One MDC period with the line released; samples what the PHY drives
    // just before the rising edge, as the initiator would.
    task automatic mdc_bit_s(output logic o, output logic oe);
        mdio_i = 1'b1;
        repeat (HP) @(posedge clock_50m);
        o  = mdio_o;
        oe = mdio_oe;
        #1 phy_mdc = 1'b1;
        repeat (HP) @(posedge clock_50m);
        #1 phy_mdc = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) mdc_bit(v[i]);
    endtask

    task automatic settle();
        repeat (4) @(posedge clock_50m);
        #1;
    endtask

    task automatic write_frame(input logic [4:0] phy, input logic [4:0] ra,
                               input logic [15:0] d);
        send_bits(32'hFFFF_FFFF, 32);
        send_bits({16'h0, 2'b01, 2'b01, phy, ra, 2'b10}, 16);
        send_bits({16'h0, d}, 16);
        settle();
    endtask

    // Read frame: 19 sampled slots = TA1, TA2, D15..D0, one slot after D0.
    task automatic read_frame(input logic [4:0] phy, input logic [4:0] ra,
                              output logic [15:0] d, output logic [18:0] oe_v,
                              output logic ta_o);
        logic [18:0] o_v;
        send_bits(32'hFFFF_FFFF, 32);
        send_bits({18'h0, 2'b01, 2'b10, phy, ra}, 14);
        for (int i = 18; i >= 0; i--) mdc_bit_s(o_v[i], oe_v[i]);
        d    = o_v[16:1];
        ta_o = o_v[17];
        settle();
    endtask

    localparam logic [18:0] OE_RD = 19'h3FFFE;

    task automatic test_reset();
        repeat (5) @(posedge clock_50m);
        #1;
        vectors++; if (mdio_oe !== 1'b0) begin miscompares++; $display("FAIL rst_oe: got %b want 0", mdio_oe); end
        vectors++; if (mdio_o !== 1'b0) begin miscompares++; $display("FAIL rst_o: got %b want 0", mdio_o); end
        vectors++; if ({wr_valid, rd_valid, frame_err, busy} !== 4'b0) begin miscompares++; $display("FAIL rst_pulses: got %b want 0000", {wr_valid, rd_valid, frame_err, busy}); end
        vectors++; if ({wr_addr, wr_data} !== 21'h0) begin miscompares++; $display("FAIL rst_wr: got %h/%h want 0/0", wr_addr, wr_data); end
        reset = 1'b0;
        settle();
    endtask

    task automatic test_write_read_reg0();
        int w0, r0; logic [15:0] d; logic [18:0] oev; logic ta;
        w0 = wr_pulses; r0 = rd_pulses;
        write_frame(5'd1, 5'd0, 16'h1900);
        vectors++; if (wr_pulses - w0 !== 1) begin miscompares++; $display("FAIL wr0_pulse: got %0d want 1", wr_pulses - w0); end
        vectors++; if (wr_addr !== 5'd0) begin miscompares++; $display("FAIL wr0_addr: got %h want 0", wr_addr); end
        vectors++; if (wr_data !== 16'h1900) begin miscompares++; $display("FAIL wr0_data: got %h want 1900", wr_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wr0_busy: got %b want 0", busy); end
        read_frame(5'd1, 5'd0, d, oev, ta);
        vectors++; if (d !== 16'h1900) begin miscompares++; $display("FAIL rd0_data: got %h want 1900", d); end
        vectors++; if (rd_pulses - r0 !== 1) begin miscompares++; $display("FAIL rd0_pulse: got %0d want 1", rd_pulses - r0); end
    endtask

    task automatic test_self_clear();
        logic [15:0] d; logic [18:0] oev; logic ta;
        write_frame(5'd1, 5'd0, 16'h9140);
        vectors++; if (wr_data !== 16'h9140) begin miscompares++; $display("FAIL sc_wdata: got %h want 9140", wr_data); end
        read_frame(5'd1, 5'd0, d, oev, ta);
        vectors++; if (d !== 16'h1140) begin miscompares++; $display("FAIL sc_softrst: got %h want 1140", d); end
        write_frame(5'd1, 5'd0, 16'h1340);
        read_frame(5'd1, 5'd0, d, oev, ta);
        vectors++; if (d !== 16'h1140) begin miscompares++; $display("FAIL sc_restart_an: got %h want 1140", d); end
    endtask

    task automatic test_read_id();
        int r0, w0; logic [15:0] d; logic [18:0] oev; logic ta;
        r0 = rd_pulses;
        read_frame(5'd1, 5'd2, d, oev, ta);
        vectors++; if (d !== 16'h0141) begin miscompares++; $display("FAIL id1_data: got %h want 0141", d); end
        vectors++; if (oev !== OE_RD) begin miscompares++; $display("FAIL id1_oe: got %h want %h", oev, OE_RD); end
        vectors++; if (ta !== 1'b0) begin miscompares++; $display("FAIL id1_ta: got %b want 0", ta); end
        vectors++; if (rd_pulses - r0 !== 1) begin miscompares++; $display("FAIL id1_pulse: got %0d want 1", rd_pulses - r0); end
        read_frame(5'd1, 5'd3, d, oev, ta);
        vectors++; if (d !== 16'h0DD1) begin miscompares++; $display("FAIL id2_data: got %h want 0dd1", d); end
        w0 = wr_pulses;
        write_frame(5'd1, 5'd2, 16'hFFFF);
        vectors++; if (wr_pulses - w0 !== 1) begin miscompares++; $display("FAIL id_ro_pulse: got %0d want 1", wr_pulses - w0); end
        vectors++; if (wr_addr !== 5'd2) begin miscompares++; $display("FAIL id_ro_addr: got %h want 2", wr_addr); end
        read_frame(5'd1, 5'd2, d, oev, ta);
        vectors++; if (d !== 16'h0141) begin miscompares++; $display("FAIL id_ro_keep: got %h want 0141", d); end
    endtask

    task automatic test_reg1_link();
        logic [15:0] d; logic [18:0] oev; logic ta;
        link_up = 1'b1;
        read_frame(5'd1, 5'd1, d, oev, ta);
        vectors++; if (d !== 16'h794D) begin miscompares++; $display("FAIL r1_up: got %h want 794d", d); end
        link_up = 1'b0;
        read_frame(5'd1, 5'd1, d, oev, ta);
        vectors++; if (d !== 16'h7949) begin miscompares++; $display("FAIL r1_down: got %h want 7949", d); end
    endtask

    task automatic test_wrong_phy();
        int w0, r0, oe0; logic [15:0] d; logic [18:0] oev; logic ta;
        w0 = wr_pulses; r0 = rd_pulses; oe0 = oe_cyc;
        write_frame(5'd5, 5'd4, 16'hBEEF);
        read_frame(5'd5, 5'd4, d, oev, ta);
        vectors++; if (wr_pulses - w0 !== 0) begin miscompares++; $display("FAIL ph5_wr: got %0d want 0", wr_pulses - w0); end
        vectors++; if (rd_pulses - r0 !== 0) begin miscompares++; $display("FAIL ph5_rd: got %0d want 0", rd_pulses - r0); end
        vectors++; if (oe_cyc - oe0 !== 0) begin miscompares++; $display("FAIL ph5_oe: got %0d cycles want 0", oe_cyc - oe0); end
        write_frame(5'd1, 5'd4, 16'hA5A5);
        vectors++; if (wr_pulses - w0 !== 1) begin miscompares++; $display("FAIL ph1_wr: got %0d want 1", wr_pulses - w0); end
        read_frame(5'd1, 5'd4, d, oev, ta);
        vectors++; if (d !== 16'hA5A5) begin miscompares++; $display("FAIL ph1_rd: got %h want a5a5", d); end
    endtask

    task automatic test_short_preamble();
        int w0, b0, e0;
        w0 = wr_pulses; b0 = busy_cyc; e0 = err_pulses;
        mdc_bit(1'b0);
        send_bits(32'h7FFF_FFFF, 31);
        send_bits({16'h0, 2'b01, 2'b01, 5'd1, 5'd4, 2'b10}, 16);
        send_bits(32'h0000_1234, 16);
        settle();
        vectors++; if (busy_cyc - b0 !== 0) begin miscompares++; $display("FAIL pre31_busy: got %0d cycles want 0", busy_cyc - b0); end
        vectors++; if (wr_pulses - w0 !== 0) begin miscompares++; $display("FAIL pre31_wr: got %0d want 0", wr_pulses - w0); end
        vectors++; if (err_pulses - e0 !== 0) begin miscompares++; $display("FAIL pre31_err: got %0d want 0", err_pulses - e0); end
    endtask

    task automatic test_frame_errors();
        int e0, w0; logic [15:0] d; logic [18:0] oev; logic ta;
        e0 = err_pulses; w0 = wr_pulses;
        send_bits(32'hFFFF_FFFF, 32);
        send_bits(32'h7, 4);                  // ST 01, OP 11
        settle();
        vectors++; if (err_pulses - e0 !== 1) begin miscompares++; $display("FAIL op11_err: got %0d want 1", err_pulses - e0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL op11_busy: got %b want 0", busy); end
        send_bits(32'hFFFF_FFFF, 32);
        send_bits(32'h0, 2);                  // ST 00
        settle();
        vectors++; if (err_pulses - e0 !== 2) begin miscompares++; $display("FAIL st00_err: got %0d want 2", err_pulses - e0); end
        send_bits(32'hFFFF_FFFF, 32);
        send_bits({18'h0, 2'b01, 2'b01, 5'd1, 5'd4, 1'b0}, 15);  // bad TA
        settle();
        vectors++; if (err_pulses - e0 !== 3) begin miscompares++; $display("FAIL ta0_err: got %0d want 3", err_pulses - e0); end
        vectors++; if (wr_pulses - w0 !== 0) begin miscompares++; $display("FAIL ta0_wr: got %0d want 0", wr_pulses - w0); end
        read_frame(5'd1, 5'd4, d, oev, ta);
        vectors++; if (d !== 16'hA5A5) begin miscompares++; $display("FAIL err_resync: got %h want a5a5", d); end
    endtask

    task automatic test_mdc_timeout();
        int e0; logic o, oe;
        e0 = err_pulses;
        send_bits(32'hFFFF_FFFF, 32);
        send_bits({18'h0, 2'b01, 2'b10, 5'd1, 5'd0}, 14);
        for (int i = 0; i < 4; i++) mdc_bit_s(o, oe);
        settle();
        vectors++; if (mdio_oe !== 1'b1) begin miscompares++; $display("FAIL tmo_pre_oe: got %b want 1", mdio_oe); end
        repeat (65536 + 20) @(posedge clock_50m);
        #1;
        vectors++; if (mdio_oe !== 1'b0) begin miscompares++; $display("FAIL tmo_oe: got %b want 0", mdio_oe); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL tmo_busy: got %b want 0", busy); end
        vectors++; if (err_pulses - e0 !== 1) begin miscompares++; $display("FAIL tmo_err: got %0d want 1", err_pulses - e0); end
    endtask

    task automatic test_reset_mid_op();
        int w0; logic o, oe; logic [15:0] d; logic [18:0] oev; logic ta;
        write_frame(5'd1, 5'd0, 16'h0100);
        send_bits(32'hFFFF_FFFF, 32);
        send_bits({18'h0, 2'b01, 2'b10, 5'd1, 5'd4}, 14);
        for (int i = 0; i < 6; i++) mdc_bit_s(o, oe);
        vectors++; if (mdio_oe !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_oe: got %b want 1", mdio_oe); end
        reset = 1'b1;
        @(posedge clock_50m);
        #1;
        vectors++; if (mdio_oe !== 1'b0) begin miscompares++; $display("FAIL rmid_oe: got %b want 0", mdio_oe); end
        reset = 1'b0;
        w0 = wr_pulses;
        send_bits(32'hFFFF_FFFF, 32);
        send_bits({16'h0, 2'b01, 2'b01, 5'd1, 5'd4, 2'b10}, 16);
        send_bits(32'h0000_00FF, 8);
        reset = 1'b1;
        repeat (2) @(posedge clock_50m);
        #1 reset = 1'b0;
        send_bits(32'h0000_00FF, 8);
        settle();
        vectors++; if (wr_pulses - w0 !== 0) begin miscompares++; $display("FAIL rmid_wr: got %0d want 0", wr_pulses - w0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", busy); end
        read_frame(5'd1, 5'd0, d, oev, ta);
        vectors++; if (d !== 16'h1140) begin miscompares++; $display("FAIL rmid_reg0: got %h want 1140", d); end
        read_frame(5'd1, 5'd4, d, oev, ta);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL rmid_reg4: got %h want 0000", d); end
    endtask

    initial begin
        test_reset();
        test_write_read_reg0();
        test_self_clear();
        test_read_id();
        test_reg1_link();
        test_wrong_phy();
        test_short_preamble();
        test_frame_errors();
        test_mdc_timeout();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
